// File: rtl/hsaf_pkg.sv
// Shared constants for the hsaflms datapath and its adaptation controller.
// The controller's default latency is derived here so both sides stay consistent.
package hsaf_pkg;

    localparam int unsigned DP_IN_STAGES  = 1;
    localparam int unsigned DP_FIR_STAGES = 5;
    localparam int unsigned DP_NL_STAGES  = 3;
    localparam int unsigned DP_ERR_STAGES = 2;

    // Cycles from a sample on signal_in to its error on error_d.
    localparam int unsigned DP_LAT = DP_IN_STAGES + DP_FIR_STAGES + DP_NL_STAGES + DP_ERR_STAGES;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFlush  = 2'd1,
        StRun    = 2'd2,
        StFrozen = 2'd3
    } state_e;

endpackage

// File: rtl/err_conv_monitor.sv
// Windowed |error| accumulator: after every 2^WIN_LOG valid errors the window sum is
// compared against the threshold and the converged flag is updated.
module err_conv_monitor #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned WIN_LOG = 6,
    parameter int unsigned ACC_W   = WIDTH + WIN_LOG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             err_valid,
    input  logic [WIDTH-1:0] dp_error,
    input  logic [ACC_W-1:0] conv_thresh,
    output logic             converged
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]   err_abs;
    logic [ACC_W-1:0]   acc_q, acc_next;
    logic [WIN_LOG-1:0] cnt_q;
    logic               conv_q;

    // The most negative code has no positive twin; clamp it.
    always_comb begin
        err_abs = dp_error;
        if (dp_error == MIN_NEG) begin
            err_abs = MAX_POS;
        end else if (dp_error[WIDTH-1]) begin
            err_abs = ~dp_error + 1'b1;
        end
    end

    assign acc_next  = acc_q + ACC_W'(err_abs);
    assign converged = conv_q;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            conv_q <= 1'b0;
        end else if (err_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) begin
                conv_q <= (acc_next < conv_thresh);
                acc_q  <= '0;
            end else begin
                acc_q <= acc_next;
            end
        end
    end

endmodule

// File: rtl/hsaf_adapt_ctrl.sv
// Sequencer for the free-running hsaflms datapath: flush after start, feed one sample
// pair per clock, gate adaptation, tag error outputs and monitor convergence.
module hsaf_adapt_ctrl
    import hsaf_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned L_ORD   = 32,
    parameter int unsigned LAT     = DP_LAT,
    parameter int unsigned WIN_LOG = 6,
    parameter int unsigned ACC_W   = WIDTH + WIN_LOG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             freeze,
    input  logic             auto_freeze,
    input  logic [ACC_W-1:0] conv_thresh,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_signal,
    input  logic [WIDTH-1:0] in_desired,
    output logic [WIDTH-1:0] dp_signal,
    output logic [WIDTH-1:0] dp_desired,
    output logic             adapt_en,
    input  logic [WIDTH-1:0] dp_error,
    output logic             err_valid,
    output logic             underrun,
    output logic             converged,
    output logic [1:0]       state_o
);

    localparam int unsigned     FLUSH_LEN  = L_ORD + LAT;
    localparam int unsigned     CNT_W      = $clog2(FLUSH_LEN + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [WIDTH-1:0] dp_signal_q, dp_desired_q;
    logic             adapt_en_q, tag_q, underrun_q;
    logic [LAT-1:0]   tag_sr_q;
    logic             active, accept, freeze_cond, flush_entry;

    assign active      = (state_q == StRun) || (state_q == StFrozen);
    assign accept      = active && in_valid;
    assign freeze_cond = freeze || (auto_freeze && converged);
    assign flush_entry = (state_q == StIdle) && start && !stop;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (flush_entry) begin
                    state_d     = StFlush;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            StFlush: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (flush_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (freeze_cond) begin
                    state_d = StFrozen;
                end
            end
            StFrozen: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (!freeze_cond) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            flush_cnt_q  <= '0;
            dp_signal_q  <= '0;
            dp_desired_q <= '0;
            adapt_en_q   <= 1'b0;
            tag_q        <= 1'b0;
            tag_sr_q     <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            dp_signal_q  <= accept ? in_signal : '0;
            dp_desired_q <= accept ? in_desired : '0;
            adapt_en_q   <= accept && (state_q == StRun);
            tag_q        <= accept;
            // Tag rides alongside its sample through the datapath latency.
            tag_sr_q     <= (tag_sr_q << 1) | LAT'(tag_q);
            if (flush_entry) begin
                underrun_q <= 1'b0;
            end else if (active && !in_valid) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign in_ready   = active;
    assign dp_signal  = dp_signal_q;
    assign dp_desired = dp_desired_q;
    assign adapt_en   = adapt_en_q;
    assign err_valid  = tag_sr_q[LAT-1];
    assign underrun   = underrun_q;
    assign state_o    = state_q;

    err_conv_monitor #(
        .WIDTH   (WIDTH),
        .WIN_LOG (WIN_LOG),
        .ACC_W   (ACC_W)
    ) u_conv_mon (
        .clk         (clk),
        .reset       (reset),
        .clear       (flush_entry),
        .err_valid   (err_valid),
        .dp_error    (dp_error),
        .conv_thresh (conv_thresh),
        .converged   (converged)
    );

endmodule

// File: tb/tb_hsaf_adapt_ctrl.sv
// Randomized scoreboard bench for hsaf_adapt_ctrl against a cycle-level reference model.
module tb_hsaf_adapt_ctrl;

    localparam int WIDTH     = 16;
    localparam int L_ORD     = 32;
    localparam int LAT       = 11;
    localparam int WIN_LOG   = 6;
    localparam int ACC_W     = WIDTH + WIN_LOG;
    localparam int FLUSH_LEN = L_ORD + LAT;
    localparam int WIN       = 1 << WIN_LOG;

    logic             clk = 1'b0;
    logic             reset, start, stop, freeze, auto_freeze;
    logic [ACC_W-1:0] conv_thresh;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_signal, in_desired, dp_signal, dp_desired, dp_error;
    logic             adapt_en, err_valid, underrun, converged;
    logic [1:0]       state_o;

    hsaf_adapt_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .freeze      (freeze),
        .auto_freeze (auto_freeze),
        .conv_thresh (conv_thresh),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signal   (in_signal),
        .in_desired  (in_desired),
        .dp_signal   (dp_signal),
        .dp_desired  (dp_desired),
        .adapt_en    (adapt_en),
        .dp_error    (dp_error),
        .err_valid   (err_valid),
        .underrun    (underrun),
        .converged   (converged),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        int               cyc;
        logic [WIDTH-1:0] sig;
        logic [WIDTH-1:0] des;
        logic             adapt;
        logic             ready;
        logic             und;
        logic             conv;
        logic [1:0]       st;
    } exp_t;

    exp_t exp_q[$];
    int   due_q[$];
    int   due_m[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (mode uses the external state codes).
    int m_mode = 0, m_flush = 0, m_acc = 0, m_n = 0, m_ev = 0;
    bit m_conv = 0, m_und = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, ecnt, act, req);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents the cycle it refers to.
    always @(negedge clk) begin
        exp_t e;
        bit   due_now;
        if (ecnt >= 1) begin
            due_now = (due_q.size() > 0) && (due_q[0] == ecnt);
            check("err_valid", 32'(err_valid), 32'(due_now));
            if (due_now) void'(due_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == ecnt) begin
            e = exp_q.pop_front();
            check("state_o", 32'(state_o), 32'(e.st));
            check("in_ready", 32'(in_ready), 32'(e.ready));
            check("dp_signal", 32'(dp_signal), 32'(e.sig));
            check("dp_desired", 32'(dp_desired), 32'(e.des));
            check("adapt_en", 32'(adapt_en), 32'(e.adapt));
            check("underrun", 32'(underrun), 32'(e.und));
            check("converged", 32'(converged), 32'(e.conv));
        end
    end

    // Advance one clock: predict the outcome of the coming edge from the current inputs.
    task automatic step();
        exp_t e;
        int   k, ev_val, a;
        bit   ev, acc, entering, fc;
        int   cur;
        k  = ecnt + 1;
        ev = (due_m.size() > 0) && (due_m[0] == ecnt);
        if (ev) void'(due_m.pop_front());
        e.sig   = '0;
        e.des   = '0;
        e.adapt = 1'b0;
        if (!reset) begin
            m_mode = 0; m_flush = 0; m_acc = 0; m_n = 0; m_ev = 0;
            m_conv = 0; m_und = 0;
            due_m.delete();
            while (due_q.size() > 0 && due_q[$] >= k) void'(due_q.pop_back());
        end else begin
            cur      = m_mode;
            acc      = (cur >= 2) && in_valid;
            entering = (cur == 0) && start && !stop;
            fc       = freeze || (auto_freeze && m_conv);
            if (entering) begin
                m_acc = 0; m_n = 0; m_ev = 0; m_conv = 0; m_und = 0;
            end else begin
                if (ev) begin
                    ev_val = int'($signed(dp_error));
                    a = (ev_val == -32768) ? 32767 : ((ev_val < 0) ? -ev_val : ev_val);
                    m_acc += a;
                    m_n++;
                    m_ev++;
                    if (m_n == WIN) begin
                        m_conv = (m_acc < int'(conv_thresh));
                        m_acc  = 0;
                        m_n    = 0;
                    end
                end
                if (cur >= 2 && !in_valid) m_und = 1;
            end
            case (cur)
                0: if (entering) begin m_mode = 1; m_flush = 0; end
                1: begin
                    if (stop) m_mode = 0;
                    else begin
                        m_flush++;
                        if (m_flush == FLUSH_LEN) m_mode = 2;
                    end
                end
                default: m_mode = stop ? 0 : (fc ? 3 : 2);
            endcase
            if (acc) begin
                e.sig   = in_signal;
                e.des   = in_desired;
                e.adapt = (cur == 2);
                due_m.push_back(k + LAT);
                due_q.push_back(k + LAT);
            end
        end
        e.cyc   = k;
        e.st    = 2'(m_mode);
        e.ready = (m_mode >= 2);
        e.und   = m_und;
        e.conv  = m_conv;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_pair();
        in_signal  = 16'($urandom);
        in_desired = 16'($urandom);
    endtask

    initial begin
        int budget;
        int tmp;
        reset = 0; start = 0; stop = 0; freeze = 0; auto_freeze = 0;
        conv_thresh = '0; in_valid = 1; dp_error = '0;
        rand_pair();
        @(posedge clk);
        #1;
        repeat (3) begin rand_pair(); step(); end
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd0);

        // Start and flush; inputs offered during flush must be ignored.
        reset = 1;
        start = 1;
        step();
        start = 0;
        repeat (FLUSH_LEN) begin rand_pair(); step(); end
        check("run_after_flush", 32'(state_o), 32'd2);

        // Single directed beat followed by bubbles.
        in_signal = 16'h1000;
        step();
        in_valid = 0;
        repeat (LAT + 3) step();
        check("underrun_sticky", 32'(underrun), 32'd1);

        // Randomized traffic with freeze/auto-freeze activity.
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom % 5) != 0;
            rand_pair();
            tmp = int'($urandom_range(0, 255)) - 128;
            dp_error = ($urandom % 64 == 0) ? 16'h8000 : 16'(tmp);
            if ($urandom % 23 == 0) freeze = ~freeze;
            if (i % 100 == 0) begin
                auto_freeze = $urandom % 2;
                conv_thresh = ACC_W'($urandom_range(0, 64 * 200));
            end
            step();
        end

        // Stop wins over start while running; then stop+start in IDLE stays IDLE.
        stop = 1; start = 1;
        step();
        stop = 0; start = 0; freeze = 0; auto_freeze = 0; in_valid = 0;
        repeat (LAT + 3) step();
        start = 1; stop = 1;
        step();
        start = 0; stop = 0;
        step();
        check("idle_after_stop_start", 32'(state_o), 32'd0);

        // Convergence with auto-freeze, then divergence.
        start = 1;
        step();
        start = 0;
        repeat (FLUSH_LEN) step();
        check("underrun_clear_after_flush", 32'(underrun), 32'd0);
        auto_freeze = 1;
        conv_thresh = ACC_W'(64 * 16);
        dp_error    = 16'h0008;
        in_valid    = 1;
        budget      = 0;
        while (m_ev < WIN && budget < 500) begin rand_pair(); step(); budget++; end
        dp_error = 16'h0100;
        repeat (2) begin rand_pair(); step(); end
        check("conv_budget", 32'(budget < 500), 32'd1);
        check("conv_set", 32'(converged), 32'd1);
        check("auto_frozen", 32'(state_o), 32'd3);
        check("frozen_no_adapt", 32'(adapt_en), 32'd0);
        while (m_ev < 2 * WIN && budget < 1000) begin rand_pair(); step(); budget++; end
        repeat (2) begin rand_pair(); step(); end
        check("unconv_budget", 32'(budget < 1000), 32'd1);
        check("conv_cleared", 32'(converged), 32'd0);
        check("back_to_run", 32'(state_o), 32'd2);

        // Reset mid-FLUSH.
        auto_freeze = 0;
        stop = 1;
        step();
        stop = 0; in_valid = 0;
        repeat (LAT + 3) step();
        start = 1;
        step();
        start = 0;
        repeat (10) step();
        reset = 0;
        step();
        reset = 1;
        check("reset_mid_flush", 32'(state_o), 32'd0);
        repeat (5) step();

        // Reset in RUN with beats in flight and underrun set: no errors may emerge.
        start = 1;
        step();
        start = 0;
        repeat (FLUSH_LEN) step();
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 3) != 2;
            rand_pair();
            step();
        end
        reset = 0;
        step();
        reset = 1; in_valid = 0;
        check("underrun_reset", 32'(underrun), 32'd0);
        repeat (LAT + 5) step();

        @(negedge clk);
        #1;
        check("pending_errors", 32'(due_q.size()), 32'd0);
        check("pending_records", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout at edge %0d: got no finish, expected finish", ecnt);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hsaf_adapt_ctrl.md
Name: hsaf_adapt_ctrl

Overview:
- Sequencer in front of the free-running hsaflms datapath. The datapath has no clock enable.
- Accepts input/desired sample pairs over a valid/ready handshake and presents one pair per clock to the datapath.
- Flushes the datapath pipelines after start and gates adaptation (adapt_en → datapath zeroes its mu·error terms).
- Tags each datapath error output with a valid bit aligned to the datapath latency, and runs a windowed |error| convergence monitor with optional auto-freeze.

Parameters:
- WIDTH, 16, sample/error width (signed, Q-format QP).
- L_ORD, 32, linear tap count; sets flush length.
- LAT, 11, cycles from a sample on dp_signal to its error on dp_error.
- WIN_LOG, 6, convergence window = 2^WIN_LOG valid errors.
- ACC_W, WIDTH+WIN_LOG, accumulator width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  pulse: begin flush then run
- stop  in  1  pulse: return to IDLE
- freeze  in  1  level: suspend adaptation
- auto_freeze  in  1  level: freeze automatically when converged
- conv_thresh  in  ACC_W  unsigned window-sum threshold
- in_valid  in  1  sample pair valid
- in_ready  out  1  sample pair accepted this cycle
- in_signal  in  WIDTH  input sample
- in_desired  in  WIDTH  desired sample
- dp_signal  out  WIDTH  registered to datapath signal_in
- dp_desired  out  WIDTH  registered to datapath desired_in
- adapt_en  out  1  registered, datapath weight-update enable
- dp_error  in  WIDTH  datapath error_d
- err_valid  out  1  dp_error carries a real sample's error
- underrun  out  1  sticky: bubble inserted during RUN/FROZEN
- converged  out  1  convergence flag
- state_o  out  2  current state code

Behaviour:
- Reset (reset==0 at posedge) forces IDLE. All outputs are 0 and sample regs are 0. Shift register, counters, accumulator and sticky flags are cleared. Reset mid-operation discards everything; no drain.
- State codes: IDLE=0, FLUSH=1, RUN=2, FROZEN=3.
- IDLE:
  - in_ready=0; dp_signal/dp_desired=0; adapt_en=0.
  - start → FLUSH and load flush counter with L_ORD+LAT-1.
- FLUSH:
  - Drives zeros, in_ready=0, adapt_en=0; counter decrements each cycle.
  - At 0 → RUN. Flush lasts exactly L_ORD+LAT cycles (43 at defaults).
- RUN:
  - in_ready=1 combinationally.
  - If in_valid: register in_signal/in_desired onto dp_* next cycle, tag=1, adapt_en=1.
  - If !in_valid: register 0/0, tag=0, adapt_en=0, set underrun.
  - freeze | (auto_freeze & converged) → FROZEN.
- FROZEN:
  - Same sample handling as RUN, but adapt_en=0 always.
  - Returns to RUN when the freeze condition is false.
- stop: from any non-IDLE state → IDLE next cycle; beats accepted that cycle are still registered.
- Priority: stop > start. start in any state other than IDLE is ignored.
- dp_* and adapt_en are registered 1 cycle after acceptance.
- Tag path: LAT-deep shift register of the tag. err_valid = tag delayed LAT cycles from its dp_signal cycle. Shift register shifts every cycle in all states; FLUSH and IDLE inject 0.
- Convergence monitor:
  - On err_valid, add |dp_error| to acc. Saturate |−2^(WIDTH-1)| to 2^(WIDTH-1)-1.
  - Increment a WIN_LOG-bit sample counter.
  - On counter wrap: converged <= (acc_next < conv_thresh), acc cleared, update visible the cycle after the last sample.
  - converged is cleared on entry to FLUSH.
- underrun is cleared only by reset or entry to FLUSH.
- Simultaneous freeze deassert and converged with auto_freeze → stays FROZEN.

Decomposition:
- Shared package hsaf_pkg: state encoding constants; LAT default derived from datapath pipeline localparams, so filter and controller stay consistent.
- One sub-module: err_conv_monitor (abs, window accumulator, counter, threshold compare).

Test Plan:
- Reset low 3 cycles with in_valid=1 → all outputs 0, state_o=0, in_ready=0.
- start pulse → state_o=1 for 43 cycles with dp_signal=0 and adapt_en=0, then state_o=2 and in_ready=1.
- In RUN, send in_signal=0x1000 at cycle T → dp_signal=0x1000 at T+1 and err_valid=1 exactly at T+1+LAT; no other err_valid.
- in_valid low 2 cycles in RUN → dp_signal=0, adapt_en=0 those cycles, underrun=1 sticky, err_valid=0 at matching slots.
- auto_freeze=1, conv_thresh=64×0x10, feed 64 errors of 0x0008 → converged=1, state_o=3, adapt_en=0. Then feed 64 errors of 0x0100 → converged=0, state_o=2.
- stop in the same cycle as start, and reset mid-FLUSH → IDLE next cycle, no err_valid afterwards, accumulator and underrun cleared.
